rx_button_decoder: RTL and testbench

//  Console-side consumer of network_stack_rx: takes the 16-bit payload word stream of each received UDP frame.

---
 rtl/remote_pkg.sv | 9 +
 rtl/rx_button_decoder_if.sv | 20 ++
 rtl/link_watchdog.sv | 20 ++
 rtl/rx_button_decoder.sv | 109 ++++++++++
 tb/tb_rx_button_decoder.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/remote_pkg.sv
// remote_pkg: shared widths, decoder state encoding and controller-word redundancy check
package remote_pkg;
    localparam int BUTTON_W = 8;
    localparam int CTRL_WORD_W = 16;
    typedef enum logic [1:0] {IDLE, RX, CHECK} rxdec_state_t;
    function automatic logic ctrl_word_ok(input logic [CTRL_WORD_W-1:0] w);
        return w[CTRL_WORD_W-1:BUTTON_W] == w[BUTTON_W-1:0];
    endfunction
endpackage

// File: rtl/rx_button_decoder_if.sv
// rx_button_decoder_if: payload word stream in, button status out.
// RX_DECODER_STATS_EN adds the good_cnt/err_cnt frame counters.
interface rx_button_decoder_if;
    import remote_pkg::*;
    logic                   axiiv;
    logic [CTRL_WORD_W-1:0] axiid;
    logic [BUTTON_W-1:0]    buttons;
    logic                   buttons_valid;
    logic                   link_up;
    logic                   frame_err;
`ifdef RX_DECODER_STATS_EN
    logic [15:0]            good_cnt;
    logic [15:0]            err_cnt;
    modport master(output axiiv, axiid, input buttons, buttons_valid, link_up, frame_err, good_cnt, err_cnt);
    modport slave(input axiiv, axiid, output buttons, buttons_valid, link_up, frame_err, good_cnt, err_cnt);
`else
    modport master(output axiiv, axiid, input buttons, buttons_valid, link_up, frame_err);
    modport slave(input axiiv, axiid, output buttons, buttons_valid, link_up, frame_err);
`endif
endinterface

// File: rtl/link_watchdog.sv
// link_watchdog: counts cycles while the link is up; timeout is high on the last allowed cycle.
module link_watchdog #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic active,
    output logic timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_timer;
    assign timeout = active && r_timer == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_timer <= '0;
        else if (kick) r_timer <= '0;
        else if (active && r_timer != LAST) r_timer <= r_timer + 1'b1;
    end
endmodule

// File: rtl/rx_button_decoder.sv
// rx_button_decoder: pulls the controller word out of each RX frame and publishes buttons with a link watchdog.
// RX_DECODER_STATS_EN adds good/err frame counters on the interface.
module rx_button_decoder
    import remote_pkg::*;
#(
    parameter int PAYLOAD_IDX    = 12,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int IDX_W          = 8
) (
    input logic               clk,
    input logic               rst,
    rx_button_decoder_if.slave bus
);
    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W-1:0] CAP_IDX = IDX_W'(PAYLOAD_IDX);
    rxdec_state_t           r_state, w_next;
    logic [IDX_W-1:0]       r_idx;
    logic [CTRL_WORD_W-1:0] r_cap_word;
    logic                   r_have_word, r_prev_low;
    logic [BUTTON_W-1:0]    r_buttons;
    logic                   r_buttons_valid, r_link_up, r_frame_err;
    logic                   w_accept, w_commit, w_reject, w_timeout;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // a frame may only start on a low->high edge of axiiv, so a frame in flight at reset release is skipped
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.axiiv && r_prev_low;
                w_next   = w_accept ? RX : IDLE;
            end
            RX: begin
                w_accept = bus.axiiv;
                w_next   = bus.axiiv ? RX : CHECK;
            end
            CHECK: begin
                w_commit = r_have_word && ctrl_word_ok(r_cap_word);
                w_reject = !w_commit;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_cap_word  <= '0;
            r_have_word <= 1'b0;
            r_prev_low  <= 1'b0;
        end else begin
            r_prev_low <= !bus.axiiv;
            if (r_state == CHECK) begin
                r_idx       <= '0;
                r_have_word <= 1'b0;
            end else if (w_accept) begin
                if (r_idx != IDX_MAX) r_idx <= r_idx + 1'b1;
                if (r_idx == CAP_IDX && !r_have_word) begin
                    r_cap_word  <= bus.axiid;
                    r_have_word <= 1'b1;
                end
            end
        end
    end
    // a commit on the timeout cycle wins: link stays up and the watchdog restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buttons       <= '0;
            r_buttons_valid <= 1'b0;
            r_link_up       <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            r_buttons_valid <= w_commit;
            r_frame_err     <= w_reject;
            r_link_up       <= w_commit || (r_link_up && !w_timeout);
            r_buttons       <= w_commit ? r_cap_word[BUTTON_W-1:0] : w_timeout ? '0 : r_buttons;
        end
    end
    link_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .kick   (w_commit),
        .active (r_link_up),
        .timeout(w_timeout)
    );
    assign bus.buttons       = r_buttons;
    assign bus.buttons_valid = r_buttons_valid;
    assign bus.link_up       = r_link_up;
    assign bus.frame_err     = r_frame_err;
`ifdef RX_DECODER_STATS_EN
    logic [15:0] r_good_cnt, r_err_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_commit) r_good_cnt <= r_good_cnt + 1'b1;
            if (w_reject) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
    assign bus.good_cnt = r_good_cnt;
    assign bus.err_cnt  = r_err_cnt;
`endif
endmodule

// File: tb/tb_rx_button_decoder.sv
// tb_rx_button_decoder: random and directed frames, scoreboard of expected pulses, per-cycle link/buttons model.
module tb_rx_button_decoder;
    localparam int T    = 100;
    localparam int PIDX = 12;
    typedef struct {
        logic       err;
        logic [7:0] btn;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   commits = 0;
    int   last_commit = 0;
    bit   committed = 0;
    logic [7:0] last_btn = 8'h00;
    exp_t exp_q[$];
    rx_button_decoder_if bif();
    rx_button_decoder #(.PAYLOAD_IDX(PIDX), .TIMEOUT_CYCLES(T), .IDX_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // monitor: pops the scoreboard on each pulse and checks link_up/buttons every cycle
    always @(negedge clk) begin
        exp_t e;
        bit   link_exp;
        if (rst) begin
            committed = 0;
            n_chk++;
            if ({bif.buttons, bif.buttons_valid, bif.link_up, bif.frame_err} !== 11'h0) begin
                n_fail++;
                $display("FAIL reset_outputs got buttons=%h valid=%b link=%b err=%b want all 0", bif.buttons, bif.buttons_valid, bif.link_up, bif.frame_err);
            end
        end else begin
            if (bif.buttons_valid === 1'b1 || bif.frame_err === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse at cyc %0d got valid=%b err=%b want no pulse", cyc, bif.buttons_valid, bif.frame_err);
                end else begin
                    e = exp_q.pop_front();
                    if (bif.frame_err !== e.err || bif.buttons_valid !== !e.err) begin
                        n_fail++;
                        $display("FAIL pulse_kind at cyc %0d got valid=%b err=%b want err=%b", cyc, bif.buttons_valid, bif.frame_err, e.err);
                    end
                    if (!e.err) begin
                        last_btn = e.btn;
                        last_commit = cyc;
                        committed = 1;
                        commits++;
                    end
                end
            end
            link_exp = committed && (cyc - last_commit < T);
            n_chk++;
            if (bif.link_up !== link_exp || bif.buttons !== (link_exp ? last_btn : 8'h00)) begin
                n_fail++;
                $display("FAIL link_state at cyc %0d got link=%b buttons=%h want link=%b buttons=%h", cyc, bif.link_up, bif.buttons, link_exp, link_exp ? last_btn : 8'h00);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input int n, input logic [15:0] w12, input int gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            tick();
            bif.axiiv = 1'b1;
            bif.axiid = (i == PIDX) ? w12 : 16'($urandom);
        end
        tick();
        bif.axiiv = 1'b0;
        e.err = !(n > PIDX && w12[15:8] == w12[7:0]);
        e.btn = w12[7:0];
        exp_q.push_back(e);
        repeat (gap - 1) tick();
    endtask
    task automatic wait_commit(input int c0);
        for (int i = 0; i < 40 && commits == c0; i++) tick();
        n_chk++;
        if (commits == c0) begin
            n_fail++;
            $display("FAIL commit_wait got no buttons_valid within 40 cycles want one");
        end
    endtask
    initial begin
        int         c0, c1, n;
        logic [7:0]  b;
        logic [15:0] w;
        bif.axiiv = 1'b0;
        bif.axiid = 16'h0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        send_frame(14, 16'hA5A5, 3);
        send_frame(14, 16'hA55A, 3);
        send_frame(12, 16'hCCCC, 3);
        repeat (10) tick();
        n_chk++;
        if (bif.buttons !== 8'hA5 || bif.link_up !== 1'b1) begin
            n_fail++;
            $display("FAIL after_err_frames got buttons=%h link=%b want a5 1", bif.buttons, bif.link_up);
        end
        repeat (110) tick();
        n_chk++;
        if (bif.link_up !== 1'b0 || bif.buttons !== 8'h00) begin
            n_fail++;
            $display("FAIL link_timeout got link=%b buttons=%h want 0 00", bif.link_up, bif.buttons);
        end
        c0 = commits;
        send_frame(14, 16'h1111, 2);
        wait_commit(c0);
        c1 = last_commit;
        while (cyc < c1 + T - 17) tick();
        c0 = commits;
        send_frame(14, 16'h2222, 2);
        wait_commit(c0);
        n_chk++;
        if (last_commit != c1 + T || bif.link_up !== 1'b1 || bif.buttons !== 8'h22) begin
            n_fail++;
            $display("FAIL commit_on_timeout got cyc=%0d link=%b buttons=%h want cyc=%0d 1 22", last_commit, bif.link_up, bif.buttons, c1 + T);
        end
        repeat (5) tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 5) rst = 1'b1;
            if (i == 8) rst = 1'b0;
            bif.axiiv = 1'b1;
            bif.axiid = (i == PIDX) ? 16'h7777 : 16'($urandom);
        end
        tick();
        bif.axiiv = 1'b0;
        repeat (3) tick();
        c0 = commits;
        send_frame(14, 16'h0303, 3);
        wait_commit(c0);
        n_chk++;
        if (bif.buttons !== 8'h03) begin
            n_fail++;
            $display("FAIL after_reset_frame got buttons=%h want 03", bif.buttons);
        end
        for (int k = 0; k < 30; k++) begin
            n = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(4, 20);
            b = 8'($urandom);
            w = ($urandom_range(0, 2) == 0) ? 16'($urandom) : {b, b};
            send_frame(n, w, $urandom_range(2, 5));
        end
        send_frame(300, 16'h5A5A, 3);
        repeat (10) tick();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
